imem_loader: RTL and testbench

Boot-time program writer for the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes the words into consecutive word addresses starting at the reset PC, and holds the core in reset until the load completes. It sits between the host/serial front end and the instruction memory write port. The core-side instruction memory read path is unchanged.

---
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction memory writer. It takes a byte stream
//               (16-bit LE word count, then LE words) and holds the core in
//               reset while it writes.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [31:0] c_max_words = MAX_WORDS;

    state_t      state_q;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] word_q;
    logic        in_ready_q;
    logic        we_q;
    logic [31:0] wa_q;
    logic [31:0] wd_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic        w_accept;
    logic [15:0] w_len;
    logic [31:0] w_addr;

    assign w_accept = in_valid & in_ready_q;
    assign w_len    = {in_data, len_q[7:0]};
    assign w_addr   = BASE_ADDR + {14'd0, idx_q, 2'b00};

    // All outputs are registered and updated together with the state so they
    // always reflect the state the FSM is currently in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            idx_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_q     <= 24'd0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            wa_q       <= 32'd0;
            wd_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q    <= S_LEN0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                S_LEN0: begin
                    if (w_accept) begin
                        len_q[7:0] <= in_data;
                        state_q    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_accept) begin
                        len_q[15:8] <= in_data;
                        if (w_len == 16'd0) begin
                            state_q    <= S_DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else if ({16'd0, w_len} > c_max_words) begin
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q    <= S_DATA;
                            idx_q      <= 16'd0;
                            byte_cnt_q <= 2'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= in_data;
                            2'd1: word_q[15:8]  <= in_data;
                            2'd2: word_q[23:16] <= in_data;
                            default: begin
                                // Final byte goes straight to the write port.
                                state_q    <= S_WRITE;
                                in_ready_q <= 1'b0;
                                we_q       <= 1'b1;
                                wa_q       <= w_addr;
                                wd_q       <= {in_data, word_q};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    idx_q      <= idx_q + 16'd1;
                    byte_cnt_q <= 2'd0;
                    if (idx_q + 16'd1 == len_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_DATA;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign we       = we_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign busy     = busy_q;
    assign cpu_hold = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. It uses a byte-count
//               reference model and random stimulus with gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .we(we), .wa(wa), .wd(wd),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: session flag, byte count, word count, pending write
    bit          m_active, m_done, m_err, m_pend;
    int          m_n, m_nb, m_words;
    logic [31:0] m_wa, m_wd, m_word;

    logic [31:0] obs_wa[$];
    logic [31:0] obs_wd[$];
    int          nwe = 0;

    logic [31:0] nom_wa[4] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
    logic [31:0] nom_wd[4] = '{32'hFFC4_A303, 32'h0064_A423, 32'h0062_E233, 32'hFE42_0AE3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pend = 1'b0;
        m_n = 0; m_nb = 0; m_words = 0;
        m_wa = 32'd0; m_wd = 32'd0; m_word = 32'd0;
    endfunction

    always @(posedge clk) begin : model
        int k;
        if (rst_n) begin
            if (m_pend) begin
                m_pend = 1'b0;
                m_words++;
                if (m_words == m_n) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1; m_done = 1'b0; m_err = 1'b0;
                    m_nb = 0; m_words = 0;
                end
            end else if (in_valid) begin
                if (m_nb == 0) begin
                    m_n = int'(in_data);
                end else if (m_nb == 1) begin
                    m_n = m_n + 256 * int'(in_data);
                    if (m_n == 0) begin
                        m_active = 1'b0; m_done = 1'b1;
                    end else if (m_n > MAXW) begin
                        m_active = 1'b0; m_err = 1'b1;
                    end
                end else begin
                    k = (m_nb - 2) % 4;
                    m_word[8*k +: 8] = in_data;
                    if (k == 3) begin
                        m_pend = 1'b1;
                        m_wa   = BASE + 32'(4 * m_words);
                        m_wd   = m_word;
                    end
                end
                m_nb++;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_active);
        chk("cpu_hold", cpu_hold, m_active);
        chk("done", done, m_done);
        chk("error", error, m_err);
        chk("in_ready", in_ready, m_active && !m_pend);
        chk("we", we, m_pend);
        chk("wa", wa, m_wa);
        chk("wd", wd, m_wd);
        if (we === 1'b1) begin
            nwe++;
            obs_wa.push_back(wa);
            obs_wd.push_back(wd);
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int gap_pct, input bit noise);
        int i = 0;
        int guard = 0;
        while (i < q.size()) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = q[i];
            start    = noise && ($urandom_range(0, 9) == 0);
            if (in_valid && in_ready) i++;
            guard++;
            if (guard > 50 * q.size() + 200) begin
                checks++; errors++;
                $display("FAIL send_timeout at %0t: got %0d bytes expected %0d", $time, i, q.size());
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy !== 1'b0 && g < 10000) begin
            @(negedge clk);
            g++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_wa"}, wa, 0);
        chk({tag, "_wd"}, wd, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
    endtask

    task automatic check_nominal(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_wa"}, (i < obs_wa.size()) ? obs_wa[i] : 32'hDEAD_BEEF, nom_wa[i]);
            chk({tag, "_wd"}, (i < obs_wd.size()) ? obs_wd[i] : 32'hDEAD_BEEF, nom_wd[i]);
        end
        chk({tag, "_count"}, nwe, 4);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
    endtask

    task automatic clear_obs();
        obs_wa.delete();
        obs_wd.delete();
        nwe = 0;
    endtask

    initial begin
        logic [7:0] nom[$];
        logic [7:0] q[$];
        int g;
        int n;
        model_reset();
        nom = {8'h04, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h23, 8'hA4, 8'h64, 8'h00,
               8'h33, 8'hE2, 8'h62, 8'h00, 8'hE3, 8'h0A, 8'h42, 8'hFE};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        clear_obs();
        pulse_start();
        send_bytes(nom, 0, 0);
        wait_idle();
        check_nominal("nominal");

        clear_obs();
        pulse_start();
        chk("restart_clears_done", done, 0);
        send_bytes(nom, 50, 1);
        wait_idle();
        check_nominal("gaps");

        clear_obs();
        pulse_start();
        send_bytes('{8'h00, 8'h00}, 0, 0);
        wait_idle();
        chk("n0_count", nwe, 0);
        chk("n0_done", done, 1);

        clear_obs();
        pulse_start();
        q = {8'h00, 8'h04};
        for (int i = 0; i < 4 * MAXW; i++) q.push_back(8'($urandom));
        send_bytes(q, 0, 0);
        wait_idle();
        chk("n1024_count", nwe, MAXW);
        chk("n1024_last_wa", (obs_wa.size() > 0) ? obs_wa[obs_wa.size() - 1] : 32'hDEAD_BEEF, 32'h0000_1FFC);
        chk("n1024_done", done, 1);

        clear_obs();
        pulse_start();
        send_bytes('{8'h01, 8'h04}, 0, 0);
        @(negedge clk); in_valid = 1'b1; in_data = 8'h5A;
        repeat (6) @(negedge clk);
        chk("n1025_error", error, 1);
        chk("n1025_in_ready", in_ready, 0);
        chk("n1025_done", done, 0);
        in_valid = 1'b0;
        chk("n1025_count", nwe, 0);

        // Asynchronous reset after two of four words
        clear_obs();
        pulse_start();
        q = nom[0:9];
        send_bytes(q, 0, 0);
        g = 0;
        while (m_words < 2 && g < 100) begin @(negedge clk); g++; end
        chk("mid_words_written", nwe, 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mid_no_more_we", nwe, 2);
        clear_obs();
        pulse_start();
        send_bytes(nom, 30, 0);
        wait_idle();
        check_nominal("reload");

        clear_obs();
        pulse_start();
        chk("restart2_clears_done", done, 0);
        send_bytes('{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00}, 0, 0);
        wait_idle();
        chk("n1_count", nwe, 1);
        chk("n1_wa", (obs_wa.size() > 0) ? obs_wa[0] : 32'hDEAD_BEEF, 32'h0000_1000);
        chk("n1_wd", (obs_wd.size() > 0) ? obs_wd[0] : 32'hDEAD_BEEF, 32'h0000_0013);

        for (int s = 0; s < 8; s++) begin
            clear_obs();
            n = $urandom_range(1, 12);
            q = {8'(n), 8'h00};
            for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            pulse_start();
            send_bytes(q, $urandom_range(0, 60), 1);
            wait_idle();
            chk("rand_count", nwe, n);
            chk("rand_done", done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog at %0t: got no finish expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
